// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the RAM-backed FWFT FIFO.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32'd8;
  localparam int unsigned DEFAULT_DEPTH      = 32'd16;
  localparam int unsigned DEFAULT_ALMOST_GAP = 32'd2;

  // Pointer width; the occupancy counter needs one extra bit to reach DEPTH.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/simple_dualport_mem.sv
// Simple dual-port RAM: Port A writes, Port B reads with one cycle of registered latency.
module simple_dualport_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] doutb_q;

  // Storage array and registered read; a same-address read and write returns the old word.
  always_ff @(posedge clk) begin
    if (wea) begin
      mem_q[addra] <= dina;
    end
    doutb_q <= mem_q[addrb];
  end

  assign doutb = doutb_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// First-word-fall-through FIFO controller around simple_dualport_mem.
// Optional almost_full/almost_empty ports are enabled by defining FIFO_ALMOST_FLAGS_EN.
module mem_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ALMOST_GAP = DEFAULT_ALMOST_GAP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]        count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                          almost_full,
  output logic                          almost_empty
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mem_fifo_ctrl: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             push;
  logic             pop;
  logic             wea;
  logic [PTR_W-1:0] addrb;

  // Handshakes and RAM port sequencing; addrb looks ahead so doutb refills on the popping edge.
  always_comb begin
    push = in_valid & in_ready;
    pop  = out_valid_q & out_ready;
    wea  = push & ~flush;
    if (pop) begin
      addrb = rd_ptr_q + PTR_W'(1);
    end else begin
      addrb = rd_ptr_q;
    end
  end

  // Next-state for pointers, occupancy and head-valid; flush overrides any transfer.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      // A word written on this edge is not yet readable, so only older words count.
      out_valid_d = (cnt_q > CNT_W'(pop));
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (cnt_q < CNT_W'(DEPTH));
  assign out_valid = out_valid_q;
  assign count     = cnt_q;

`ifdef FIFO_ALMOST_FLAGS_EN
  if (ALMOST_GAP >= DEPTH) begin : g_bad_gap
    $error("mem_fifo_ctrl: ALMOST_GAP must be smaller than DEPTH");
  end

  assign almost_full  = (cnt_q >= CNT_W'(DEPTH - ALMOST_GAP));
  assign almost_empty = (cnt_q <= CNT_W'(ALMOST_GAP));
`endif

  simple_dualport_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk   (clk),
    .wea   (wea),
    .addra (wr_ptr_q),
    .dina  (in_data),
    .addrb (addrb),
    .doutb (out_data)
  );

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Scoreboard bench for mem_fifo_ctrl: directed scenarios followed by random traffic.
module tb_mem_fifo_ctrl;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int GAP = 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [4:0]    count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  mem_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .ALMOST_GAP (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored words tagged with the edge that wrote them.
  typedef struct {
    logic [DW-1:0] d;
    int            stamp;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] sb[$];
  int            edge_n = 0;
  bit            mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic bit model_head_visible();
    return (mq.size() > 0) && (mq[0].stamp < edge_n);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  // One clock of stimulus; after the edge, the model applies the same transfer rules.
  task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
    bit   vis;
    bit   rdy;
    ent_t e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    vis = model_head_visible();
    rdy = (mq.size() < DEP);
    edge_n++;
    if (fl) begin
      mq.delete();
      sb.delete();
    end else begin
      if (vis && ordy) void'(mq.pop_front());
      if (iv && rdy) begin
        e.d     = d;
        e.stamp = edge_n;
        mq.push_back(e);
        sb.push_back(d);
      end
    end
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("count", int'(count), mq.size());
        chk("in_ready", int'(in_ready), int'(mq.size() < DEP));
        chk("out_valid", int'(out_valid), int'(model_head_visible()));
`ifdef FIFO_ALMOST_FLAGS_EN
        chk("almost_full", int'(almost_full), int'(mq.size() >= DEP - GAP));
        chk("almost_empty", int'(almost_empty), int'(mq.size() <= GAP));
`endif
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output at edge %0d: got data %0d expected no word", edge_n, out_data);
          end else begin
            chk("out_data", int'(out_data), int'(sb[0]));
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle after reset.
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Single word, held, then popped.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, attempt an overflow push, then drain in order.
    for (int i = 0; i < DEP; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEP; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming with wrap-around.
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h40 + 8'(i)), 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush beats a simultaneous push; next push shows up two edges later.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + 8'(i)), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic including occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          8'($urandom_range(0, 255)),
          ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    repeat (DEP + 4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    mon_en = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
# mem_fifo_ctrl

Synchronous first-word-fall-through FIFO built around one `simple_dualport_mem` instance. The controller owns the write port (Port A) and read port (Port B) of the RAM. It sequences them from a valid/ready push interface and a valid/ready pop interface, and it tracks occupancy. It sits between a producer and a consumer running on the same clock, and it hides the RAM's 1-cycle registered read latency after the first word.

## Interface
- `DATA_WIDTH`, default 8: word width.
- `DEPTH`, default 16: number of entries; must be a power of two and at least 2.
- `ALMOST_GAP`, default 2: threshold for the almost flags. It is used only when `FIFO_ALMOST_FLAGS_EN` is defined.
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous clear of all contents.
- `in_valid`, input, 1: producer has a word.
- `in_ready`, output, 1: FIFO can accept a word; equals `cnt < DEPTH`.
- `in_data`, input, `DATA_WIDTH`: push data.
- `out_valid`, output, 1: head word is presented on `out_data`.
- `out_ready`, input, 1: consumer takes the head word.
- `out_data`, output, `DATA_WIDTH`: head word; driven directly by the RAM `doutb`.
- `count`, output, `$clog2(DEPTH)+1`: occupancy, 0 to `DEPTH`.
- `almost_full`, output, 1: present only with the macro.
- `almost_empty`, output, 1: present only with the macro.

## Operation
- Push and pop conditions:
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- Internal registers:
  - `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH` with no special case.
  - `cnt`, driving `count`.
  - `out_valid`.
- RAM write port: `wea` = push, `addra` = `wr_ptr`, `dina` = `in_data`.
- RAM read port: `addrb` = pop ? `rd_ptr+1` : `rd_ptr`, computed combinationally. This lets `doutb` load the next head on the same edge that pops the current head.
- Update rules on each edge:
  - `cnt` moves by +1 on push only, −1 on pop only, and is unchanged when push and pop occur together.
  - `wr_ptr` increments on push.
  - `rd_ptr` increments on pop.
- Next `out_valid` = `(cnt − pop) > 0`, evaluated with `cnt` as it was before the edge.
  - This excludes a word written on the same edge, because the RAM would return stale data for it.
  - The head word is therefore visible one edge after it is written.
- Full condition:
  - `in_ready` is 0 when `cnt == DEPTH`.
  - There is no pass-through: a pop while full does not allow a push in the same cycle.
- Empty condition: `out_valid` is 0, and `out_data` holds don't-care RAM contents.
- Flush:
  - `flush=1` sets `wr_ptr`, `rd_ptr` and `cnt` to 0 and `out_valid` to 0 at the next edge.
  - Flush has priority over push and pop. Any push in that cycle is dropped, and the RAM write is suppressed (`wea` = push & ~`flush`).
- Reset:
  - Asserting `rst_n` low clears the pointers, `cnt` and `out_valid` immediately. In-flight data is discarded.
  - RAM contents are not reset.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `count`=0, `almost_empty`=1, `almost_full`=0. `out_data` is undefined.
- Push-to-visible latency when the FIFO is empty: a word accepted at edge E0 gives `out_valid`=1 after edge E1, with `out_data` equal to that word.
- Throughput after the first word: one pop per cycle, with no bubbles under continuous push and pop.
- Holding behaviour: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` stay stable. The head entry is not rewritten until it is popped.
- `count`, `in_ready` and the almost flags are all derived from registered state, so each changes only after an edge.

## Configuration
- Macro `FIFO_ALMOST_FLAGS_EN`, when defined:
  - Adds the ports `almost_full` = `cnt >= DEPTH−ALMOST_GAP` and `almost_empty` = `cnt <= ALMOST_GAP`.
  - Adds the parameter check `ALMOST_GAP < DEPTH`.
- When the macro is undefined, neither port nor its logic exists, and `ALMOST_GAP` is ignored.

## Structure
- Package `fifo_pkg` holds:
  - `DEFAULT_DATA_WIDTH`, `DEFAULT_DEPTH` and `DEFAULT_ALMOST_GAP`.
  - A `clog2`-based helper for pointer and count widths.
- Sub-module: one `simple_dualport_mem` instance with `DATA_WIDTH` and `DEPTH` passed through. All control logic lives in `mem_fifo_ctrl`.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release and drive nothing.
  - Response: `in_ready`=1, `out_valid`=0, `count`=0.
- Single word:
  - Stimulus: push 0xA5 at edge E0, with `out_ready`=0.
  - Response: `count`=1 after E0, `out_valid`=1 with `out_data`=0xA5 after E1, and it holds until popped.
- Fill and full:
  - Stimulus: push 0x00 through 0x0F (16 words) with `out_ready`=0, then attempt a 17th push of 0xFF.
  - Response: `count`=16 and `in_ready`=0. 0xFF is not stored.
  - Then pop 16 words: they come out as 0x00 through 0x0F in order, one per cycle, and `count` returns to 0.
- Streaming wrap-around:
  - Stimulus: 40 consecutive pushes of an incrementing value with `out_ready`=1 throughout.
  - Response: after the first word, one output per cycle, in order, with no bubbles. `count` stays at 1 or 2, and the pointers wrap twice.
- Flush priority:
  - Stimulus: with 5 words stored, assert `flush` and `in_valid` together for one cycle.
  - Response: `count`=0 and `out_valid`=0 at the next edge. A following push of 0x3C appears as the head after 2 edges.
- Almost flags, with the macro defined:
  - Stimulus: fill the FIFO one word at a time.
  - Response: `almost_empty` is 1 for `cnt` 0 to 2. `almost_full` becomes 1 once `cnt` reaches 14.
  - Rerun without the macro: the design compiles and the same stream passes.
